// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift unit: operation modes and controller states.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shmode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data_i by k_i (0..STEP) positions per mode_i.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic signed [WIDTH-1:0] sdata;

    always_comb begin
        sdata  = $signed(data_i);
        data_o = data_i;
        case (mode_i)
            SH_SLL:  data_o = data_i << k_i;
            SH_SRL:  data_o = data_i >> k_i;
            SH_SRA:  data_o = $unsigned(sdata >>> k_i);
            // A right shift by WIDTH yields zero, so k_i == 0 passes data through.
            default: data_o = (data_i << k_i) | (data_i >> (WIDTH - int'(k_i)));
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROL by a run-time amount, STEP positions per clock,
// with a start/busy/done handshake so the ALU control can stall on busy_o.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int KW = $clog2(STEP + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW:0]     rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic [KW-1:0]    k;
    logic             last;
    logic [WIDTH-1:0] step_out;

    // When rem_q <= STEP it fits in KW bits, so the low slice is the exact amount.
    always_comb begin
        last = (rem_q <= (SHW+1)'(STEP));
        k    = last ? rem_q[KW-1:0] : KW'(STEP);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i (acc_q),
        .k_i    (k),
        .mode_i (mode_q),
        .data_o (step_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            SHIFT: begin
                acc_d = step_out;
                rem_d = rem_q - (SHW+1)'(k);
                if (last) begin
                    state_d = DONE;
                    res_d   = step_out;
                end
            end
            default: begin
                if (start_i) begin
                    acc_d  = data_i;
                    rem_d  = {1'b0, shamt_i};
                    mode_d = mode_i;
                    if (shamt_i != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                        res_d   = data_i;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            mode_q  <= SH_SLL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign data_o = res_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: one STEP=1 and one STEP=4 instance checked against a whole-shift model.
module tb_iter_shifter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       start;
    logic [1:0][1:0]  mode;
    logic [1:0][31:0] din;
    logic [1:0][4:0]  shamt;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0][31:0] dout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[0]), .mode_i(mode[0]),
        .data_i(din[0]), .shamt_i(shamt[0]), .busy_o(busy[0]), .done_o(done[0]),
        .data_o(dout[0])
    );

    iter_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[1]), .mode_i(mode[1]),
        .data_i(din[1]), .shamt_i(shamt[1]), .busy_o(busy[1]), .done_o(done[1]),
        .data_o(dout[1])
    );

    // Whole-amount reference: the result of shifting once by s, not s single steps.
    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d, input int s);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return d[31] ? ~((~d) >> s) : (d >> s);
            default: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
        endcase
    endfunction

    function automatic int step_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic int exp_busy(input int u, input int s);
        return (s + step_of(u) - 1) / step_of(u);
    endfunction

    task automatic do_op(input int u, input logic [1:0] m, input logic [31:0] d,
                         input logic [4:0] s, input string name);
        logic [31:0] prev;
        logic [31:0] exp;
        int          nb;
        @(negedge clk);
        prev = dout[u];
        exp  = ref_shift(m, d, int'(s));
        start[u] = 1'b1; mode[u] = m; din[u] = d; shamt[u] = s;
        @(negedge clk);
        start[u] = 1'b0; mode[u] = 2'($urandom); din[u] = $urandom; shamt[u] = 5'($urandom);
        nb = 0;
        while (busy[u] === 1'b1 && nb < 64) begin
            checks++;
            if (done[u] !== 1'b0 || dout[u] !== prev) begin
                failures++;
                $display("FAIL %s hold: done=%b data_o=%h required done=0 data_o=%h", name, done[u], dout[u], prev);
            end
            nb++;
            @(negedge clk);
        end
        checks++;
        if (nb != exp_busy(u, int'(s))) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, nb, exp_busy(u, int'(s)));
        end
        checks++;
        if (done[u] !== 1'b1) begin
            failures++;
            $display("FAIL %s done: got %b required 1", name, done[u]);
        end
        checks++;
        if (dout[u] !== exp) begin
            failures++;
            $display("FAIL %s data_o: got %h required %h", name, dout[u], exp);
        end
        @(negedge clk);
        checks++;
        if (done[u] !== 1'b0 || busy[u] !== 1'b0 || dout[u] !== exp) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b data_o=%h required 0 0 %h", name, done[u], busy[u], dout[u], exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = '0; mode = '0; din = '0; shamt = '0;
        #2 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (busy[u] !== 1'b0 || done[u] !== 1'b0 || dout[u] !== 32'h0) begin
                failures++;
                $display("FAIL reset u%0d: busy=%b done=%b data_o=%h required 0 0 0", u, busy[u], done[u], dout[u]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (busy[u] !== 1'b0 || done[u] !== 1'b0 || dout[u] !== 32'h0) begin
                failures++;
                $display("FAIL reset_hold u%0d: busy=%b done=%b data_o=%h required 0 0 0", u, busy[u], done[u], dout[u]);
            end
        end
    endtask

    task automatic test_directed();
        do_op(0, 2'b00, 32'h0000_0001, 5'd2,  "sll_1_by_2");
        do_op(0, 2'b10, 32'h8000_0000, 5'd4,  "sra_by_4");
        do_op(0, 2'b01, 32'h8000_0000, 5'd4,  "srl_by_4");
        do_op(0, 2'b11, 32'h8000_0001, 5'd1,  "rol_by_1");
        do_op(0, 2'b00, 32'hDEAD_BEEF, 5'd0,  "shamt_zero");
        do_op(0, 2'b10, 32'h8000_0000, 5'd31, "sra_max_s1");
        do_op(1, 2'b00, 32'h0000_0001, 5'd31, "sll_by_31_s4");
        do_op(1, 2'b10, 32'h9000_0000, 5'd4,  "sra_by_4_s4");
        do_op(1, 2'b11, 32'h8765_4321, 5'd7,  "rol_by_7_s4");
        do_op(1, 2'b01, 32'hDEAD_BEEF, 5'd0,  "shamt_zero_s4");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_op(0, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), "random_s1");
            do_op(1, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), "random_s4");
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] exp;
        int          nb;
        exp = ref_shift(2'b01, 32'hF0F0_F0F0, 10);
        @(negedge clk);
        start[0] = 1'b1; mode[0] = 2'b01; din[0] = 32'hF0F0_F0F0; shamt[0] = 5'd10;
        @(negedge clk);
        start[0] = 1'b0;
        nb = 0;
        while (busy[0] === 1'b1 && nb < 64) begin
            start[0] = (nb == 3);
            mode[0] = 2'b00; din[0] = 32'h0000_0001; shamt[0] = 5'd5;
            nb++;
            @(negedge clk);
        end
        start[0] = 1'b0;
        checks++;
        if (nb != 10) begin
            failures++;
            $display("FAIL ignore_start busy_cycles: got %0d required 10", nb);
        end
        checks++;
        if (done[0] !== 1'b1 || dout[0] !== exp) begin
            failures++;
            $display("FAIL ignore_start result: done=%b data_o=%h required 1 %h", done[0], dout[0], exp);
        end
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start not_queued: busy=%b done=%b required 0 0", busy[0], done[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ms [3];
        logic [31:0] ds [3];
        logic [4:0]  ss [3];
        int          nb;
        ms = '{2'b11, 2'b10, 2'b00};
        ds = '{$urandom, 32'h8421_0000, 32'hCAFE_F00D};
        ss = '{5'd13, 5'd6, 5'd0};
        @(negedge clk);
        start[1] = 1'b1; mode[1] = ms[0]; din[1] = ds[0]; shamt[1] = ss[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start[1] = 1'b0;
            nb = 0;
            while (busy[1] === 1'b1 && nb < 64) begin
                nb++;
                @(negedge clk);
            end
            checks++;
            if (nb != exp_busy(1, int'(ss[i]))) begin
                failures++;
                $display("FAIL b2b[%0d] busy_cycles: got %0d required %0d", i, nb, exp_busy(1, int'(ss[i])));
            end
            checks++;
            if (done[1] !== 1'b1 || dout[1] !== ref_shift(ms[i], ds[i], int'(ss[i]))) begin
                failures++;
                $display("FAIL b2b[%0d] result: done=%b data_o=%h required 1 %h", i, done[1], dout[1],
                         ref_shift(ms[i], ds[i], int'(ss[i])));
            end
            if (i < 2) begin
                start[1] = 1'b1; mode[1] = ms[i+1]; din[1] = ds[i+1]; shamt[1] = ss[i+1];
            end
        end
        @(negedge clk);
        checks++;
        if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b idle: busy=%b done=%b required 0 0", busy[1], done[1]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start[0] = 1'b1; mode[0] = 2'b00; din[0] = 32'h0000_1234; shamt[0] = 5'd20;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (busy[u] !== 1'b0 || done[u] !== 1'b0 || dout[u] !== 32'h0) begin
                failures++;
                $display("FAIL reset_mid u%0d: busy=%b done=%b data_o=%h required 0 0 0", u, busy[u], done[u], dout[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid aborted: activity_cycles=%0d required 0", seen);
        end
        do_op(0, 2'b11, 32'hA5A5_0F0F, 5'd9, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
